serial_tx: RTL and testbench
============================

SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: payload bits per frame; legal range >= 1.
REQ-002 Parameter CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range >= 1.
REQ-003 Port clock  input  1: single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1: asynchronous, active-high reset.
REQ-005 Port tx_valid  input  1: tx_data holds a word to send.
REQ-006 Port tx_data  input  DATA_WIDTH: parallel payload word.
REQ-007 Port tx_ready  output  1: block can accept a word (registered).
REQ-008 Port serial_out  output  1: serial line; idle level is 1 (registered).
REQ-009 Port busy  output  1: frame in progress (registered).
REQ-010 Port done  output  1: one-cycle pulse at frame completion (registered).

Function
REQ-011 The block SHALL transmit each accepted word as one frame: start bit 0, then DATA_WIDTH data bits LSB first, then stop bit 1.
REQ-012 Each frame bit SHALL be driven on serial_out for exactly CLKS_PER_BIT cycles, so a frame lasts (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP.
- IDLE -> START on accept.
- START -> DATA after CLKS_PER_BIT cycles.
- DATA -> STOP after DATA_WIDTH bits.
- STOP -> IDLE after CLKS_PER_BIT cycles.
REQ-014 Accept SHALL occur on a rising edge where tx_valid=1 and tx_ready=1; tx_data SHALL be captured into an internal shift register on that edge.
REQ-015 On the accept edge, tx_ready SHALL go 0, busy SHALL go 1, and serial_out SHALL go 0; latency from accept edge to start bit is 0 cycles.
REQ-016 tx_ready SHALL be 1 only in IDLE; tx_valid while tx_ready=0 SHALL be ignored, and no word is queued.
REQ-017 Changes on tx_data after accept SHALL NOT affect the frame in progress.
REQ-018 On the edge that ends the stop bit, state SHALL return to IDLE with tx_ready=1, busy=0, serial_out=1, and done=1 for exactly one cycle.
REQ-019 Back-to-back frames: the earliest next accept SHALL be the edge after done is asserted, so there is at least one idle-high cycle between frames.
REQ-020 Bit-period and bit-index counters SHALL be sized $clog2-style to hold CLKS_PER_BIT-1 and DATA_WIDTH-1, and SHALL wrap to 0 at each bit/state boundary.
REQ-021 When CLKS_PER_BIT=1, every frame bit SHALL last one cycle with no dropped or repeated bits.
REQ-022 In IDLE, serial_out SHALL be held at 1 and done SHALL be 0 except for the REQ-018 pulse.

Reset
REQ-023 While reset=1, regardless of clock:
- state = IDLE
- serial_out = 1
- tx_ready = 0
- busy = 0
- done = 0
- counters and shift register = 0
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately; the partial word is discarded and no done pulse is issued.
REQ-025 tx_ready SHALL rise to 1 on the first rising edge after reset deasserts.

Verification (DATA_WIDTH=8, CLKS_PER_BIT=4)
REQ-026 Single frame: accept 0xA5 -> serial_out, 4 cycles per bit, is 0,1,0,1,0,0,1,0,1,1 -> done=1 exactly 40 cycles after the accept edge, with tx_ready=1 in the same cycle.
REQ-027 Back-to-back: tx_valid held at 1 with 0x00 then 0xFF -> second accept occurs on the edge after done, and frames are separated by exactly one idle-high cycle.
REQ-028 Ignored request: pulse tx_valid with 0x3C at cycle 10 of a 0xA5 frame -> 0xA5 is sent unaltered, and 0x3C is never sent.
REQ-029 Reset mid-frame: assert reset at cycle 17 of a frame -> serial_out=1 and busy=0 immediately, no done pulse, tx_ready=1 one edge after release.
REQ-030 Data stability: change tx_data every cycle during a 0x81 frame -> the line carries 0x81 bits exactly.
REQ-031 Minimum period: with CLKS_PER_BIT=1, accept 0x5A -> 10-cycle frame 0,0,1,0,1,1,0,1,0,1, and done on the 10th edge.

Source files
------------

// File: rtl/serial_tx.sv
// serial_tx: parallel-to-serial frame transmitter.
// Sends each accepted word as one frame: a start bit (0), DATA_WIDTH data bits
// LSB first, then a stop bit (1). Every bit is held for CLKS_PER_BIT clocks.
// All outputs are registered. The line idles high.
//
// Ports
//   clock      : rising-edge clock
//   reset      : asynchronous, active-high reset
//   tx_valid   : tx_data holds a word to send
//   tx_data    : parallel payload word (sampled only on the accept edge)
//   tx_ready   : high only in IDLE; accept = tx_valid & tx_ready at an edge
//   serial_out : serial line (idle 1)
//   busy       : frame in progress
//   done       : one-cycle pulse on the edge that ends the stop bit
module serial_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  serial_out,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_MAX = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  serial_q, serial_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  bit_end;

    assign bit_end = (cnt_q == CNT_MAX);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        serial_d = serial_q;
        busy_d   = busy_q;
        ready_d  = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                serial_d = 1'b1;
                busy_d   = 1'b0;
                cnt_d    = '0;
                bit_d    = '0;
                ready_d  = 1'b1;
                if (tx_valid && ready_q) begin
                    // Start bit goes out on the accept edge itself.
                    state_d  = START;
                    shift_d  = tx_data;
                    serial_d = 1'b0;
                    busy_d   = 1'b1;
                    ready_d  = 1'b0;
                end
            end
            START: begin
                cnt_d = bit_end ? '0 : cnt_q + CW'(1);
                if (bit_end) begin
                    // Data bit n is presented from shift_q[0]; shift once per bit.
                    state_d  = DATA;
                    serial_d = shift_q[0];
                    shift_d  = shift_q >> 1;
                end
            end
            DATA: begin
                cnt_d = bit_end ? '0 : cnt_q + CW'(1);
                if (bit_end) begin
                    if (bit_q == BIT_MAX) begin
                        state_d  = STOP;
                        serial_d = 1'b1;
                        bit_d    = '0;
                    end else begin
                        bit_d    = bit_q + BW'(1);
                        serial_d = shift_q[0];
                        shift_d  = shift_q >> 1;
                    end
                end
            end
            STOP: begin
                cnt_d = bit_end ? '0 : cnt_q + CW'(1);
                if (bit_end) begin
                    state_d  = IDLE;
                    serial_d = 1'b1;
                    busy_d   = 1'b0;
                    ready_d  = 1'b1;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                serial_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tx_ready   = ready_q;
    assign serial_out = serial_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed bench for serial_tx.
// Instance dut uses DATA_WIDTH=8, CLKS_PER_BIT=4; instance dut1 uses
// CLKS_PER_BIT=1. Inputs change and outputs are sampled on the falling edge.
module tb_serial_tx;

    logic       clock;
    logic       reset;
    logic       tx_valid, tx_valid1;
    logic [7:0] tx_data, tx_data1;
    logic       tx_ready, serial_out, busy, done;
    logic       tx_ready1, serial_out1, busy1, done1;

    int n_checks;
    int n_errors;

    serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done)
    );

    serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
        .clock      (clock),
        .reset      (reset),
        .tx_valid   (tx_valid1),
        .tx_data    (tx_data1),
        .tx_ready   (tx_ready1),
        .serial_out (serial_out1),
        .busy       (busy1),
        .done       (done1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one frame on dut starting at a falling edge where tx_ready is
    // expected high. Ends on the falling edge right after done rises.
    // mode 0: plain; 1: extra request 0x3C at cycle 10; 2: tx_data scrambled
    // every cycle; 3: tx_valid held, data switched to 0xFF; 4: reset at cycle 17.
    task automatic run_frame(input logic [7:0] word, input int mode);
        logic [9:0] frame;
        frame = {1'b1, word, 1'b0};
        check("pre_ready", tx_ready, 1);
        tx_valid = 1'b1;
        tx_data  = word;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (k == 0) begin
                check("acc_ready", tx_ready, 0);
                check("acc_busy", busy, 1);
                if (mode == 3) tx_data = 8'hFF;
                else tx_valid = 1'b0;
            end
            check("bit", serial_out, frame[k/4]);
            check("no_done", done, 0);
            if (mode == 1 && k == 10) begin
                tx_valid = 1'b1;
                tx_data  = 8'h3C;
            end
            if (mode == 1 && k == 11) tx_valid = 1'b0;
            if (mode == 2) tx_data = 8'($urandom);
            if (mode == 4 && k == 17) begin
                reset = 1'b1;
                #1;
                check("rst_serial", serial_out, 1);
                check("rst_busy", busy, 0);
                check("rst_ready", tx_ready, 0);
                check("rst_done", done, 0);
                @(negedge clock);
                check("rst_hold_done", done, 0);
                check("rst_hold_serial", serial_out, 1);
                reset = 1'b0;
                @(negedge clock);
                check("rel_ready", tx_ready, 1);
                check("rel_done", done, 0);
                check("rel_busy", busy, 0);
                return;
            end
        end
        @(negedge clock);
        check("end_done", done, 1);
        check("end_ready", tx_ready, 1);
        check("end_busy", busy, 0);
        check("end_serial", serial_out, 1);
    endtask

    initial begin
        logic [9:0] frame1;
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        tx_valid1 = 1'b0;
        tx_data1  = 8'h00;

        #2;
        check("reset_serial", serial_out, 1);
        check("reset_ready", tx_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        repeat (2) @(negedge clock);
        check("reset_clk_ready", tx_ready, 0);
        check("reset_clk_serial", serial_out, 1);
        reset = 1'b0;
        @(negedge clock);
        check("first_ready", tx_ready, 1);

        // Single 0xA5 frame, then done must drop after one cycle.
        run_frame(8'hA5, 0);
        @(negedge clock);
        check("done_pulse", done, 0);
        check("idle_serial", serial_out, 1);

        // Request during a frame is dropped and never queued.
        run_frame(8'hA5, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check("ign_serial", serial_out, 1);
            check("ign_busy", busy, 0);
        end

        // tx_data churn does not disturb 0x81.
        run_frame(8'h81, 2);
        @(negedge clock);

        // Back-to-back: exactly one idle-high cycle (the done cycle) between frames.
        run_frame(8'h00, 3);
        run_frame(8'hFF, 0);
        @(negedge clock);

        // Reset mid-frame.
        run_frame(8'hA5, 4);
        @(negedge clock);
        check("post_rst_done", done, 0);
        check("post_rst_serial", serial_out, 1);

        // CLKS_PER_BIT = 1, word 0x5A.
        frame1 = {1'b1, 8'h5A, 1'b0};
        check("min_ready", tx_ready1, 1);
        tx_valid1 = 1'b1;
        tx_data1  = 8'h5A;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            tx_valid1 = 1'b0;
            tx_data1  = 8'h00;
            check("min_bit", serial_out1, frame1[k]);
            check("min_no_done", done1, 0);
        end
        @(negedge clock);
        check("min_done", done1, 1);
        check("min_end_ready", tx_ready1, 1);
        check("min_end_serial", serial_out1, 1);
        @(negedge clock);
        check("min_done_drop", done1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
